// File: rtl/fp_pkg.sv
// Shared types and constants for the binary32 add/sub alignment stage.
package fp_pkg;

    localparam logic [7:0]  FP_EXP_MAX = 8'hFF;
    localparam logic [31:0] FP_QNAN    = 32'h7FC00000;
    localparam int          SIG_W      = 27;

    typedef struct packed {
        logic        sign;
        logic [7:0]  exp;
        logic [22:0] frac;
    } fp32_t;

    // Stage-1 payload: ordered operands, alignment distance and specials.
    typedef struct packed {
        logic [23:0] mant_a;
        logic [23:0] mant_b;
        logic [7:0]  exp;
        logic [4:0]  shamt;
        logic        sign;
        logic        eff_sub;
        logic        special;
        logic [31:0] special_val;
    } fp_s1_t;

    // Stage-2 payload: adder-ready words plus side information.
    typedef struct packed {
        logic [31:0] a;
        logic [31:0] b;
        logic        cin;
        logic [7:0]  exp;
        logic        sign;
        logic        eff_sub;
        logic        special;
        logic [31:0] special_val;
    } fp_align_t;

    // Denormals and zero behave as exponent 1 with no hidden bit.
    function automatic logic [7:0] fp_eff_exp(input fp32_t v);
        return (v.exp == 8'd0) ? 8'd1 : v.exp;
    endfunction

    function automatic logic [23:0] fp_mant(input fp32_t v);
        return {v.exp != 8'd0, v.frac};
    endfunction

endpackage

// File: rtl/fp_align_stage_if.sv
// Handshake and data bundle of the alignment stage; slave is the stage's view.
interface fp_align_stage_if;

    logic        in_valid;
    logic        in_ready;
    logic [31:0] x_i;
    logic [31:0] y_i;
    logic        op_i;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] a_o;
    logic [31:0] b_o;
    logic        cin_o;
    logic [7:0]  exp_o;
    logic        sign_o;
    logic        eff_sub_o;
    logic        special_o;
    logic [31:0] special_val_o;

    modport slave (
        input  in_valid, x_i, y_i, op_i, out_ready,
        output in_ready, out_valid, a_o, b_o, cin_o, exp_o, sign_o,
               eff_sub_o, special_o, special_val_o
    );

    modport master (
        output in_valid, x_i, y_i, op_i, out_ready,
        input  in_ready, out_valid, a_o, b_o, cin_o, exp_o, sign_o,
               eff_sub_o, special_o, special_val_o
    );

endinterface

// File: rtl/fp_rshift_sticky.sv
// Saturating 27-bit right shifter with sticky; FP_ALIGN_STICKY_EN enables the
// sticky OR-reduce, otherwise the S position is forced to 0.
module fp_rshift_sticky
    import fp_pkg::*;
(
    input  logic [SIG_W-1:0] data_i,
    input  logic [4:0]       amt_i,
    output logic [SIG_W-1:0] data_o,
    output logic             sticky_o
);

    logic [SIG_W-1:0] shifted;

    assign shifted = (amt_i >= 5'(SIG_W)) ? '0 : (data_i >> amt_i);

`ifdef FP_ALIGN_STICKY_EN
    logic [SIG_W-1:0] lost_mask;

    assign lost_mask = (amt_i >= 5'(SIG_W)) ? '1
                                             : ((SIG_W'(1) << amt_i) - SIG_W'(1));
    assign data_o    = shifted;
    assign sticky_o  = |(data_i & lost_mask);
`else
    localparam logic [SIG_W-1:0] S_CLR = ~SIG_W'(1);

    assign data_o   = shifted & S_CLR;
    assign sticky_o = 1'b0;
`endif

endmodule

// File: rtl/fp_align_stage.sv
// Two-stage binary32 pre-adder alignment: order, align, invert for adder_sub.
// Sticky generation is controlled by the FP_ALIGN_STICKY_EN macro.
module fp_align_stage
    import fp_pkg::*;
(
    input logic              clk,
    input logic              rst,
    fp_align_stage_if.slave  bus
);

    fp32_t       x_in, y_in;
    logic        sy_eff, eff_sub, swap;
    logic [7:0]  ex, ey, exp_diff;
    logic [23:0] mx, my;
    logic        x_nan, y_nan, x_inf, y_inf;

    logic        s1_valid_q, s2_valid_q;
    fp_s1_t      s1_d, s1_q;
    fp_align_t   s2_d, s2_q;
    logic        s2_advance;

    logic [SIG_W-1:0] b_word, b_shift, b_aligned;
    logic             b_sticky;

    assign s2_advance   = !s2_valid_q || bus.out_ready;
    assign bus.in_ready = !s1_valid_q || s2_advance;

    // ---------------- stage 1: unpack, compare, swap, specials ----------------
    assign x_in    = bus.x_i;
    assign y_in    = bus.y_i;
    assign sy_eff  = y_in.sign ^ bus.op_i;
    assign eff_sub = x_in.sign ^ sy_eff;
    assign ex      = fp_eff_exp(x_in);
    assign ey      = fp_eff_exp(y_in);
    assign mx      = fp_mant(x_in);
    assign my      = fp_mant(y_in);
    assign swap    = (ey > ex) || ((ey == ex) && (my > mx));
    assign exp_diff = swap ? (ey - ex) : (ex - ey);

    assign x_nan = (x_in.exp == FP_EXP_MAX) && (x_in.frac != '0);
    assign y_nan = (y_in.exp == FP_EXP_MAX) && (y_in.frac != '0);
    assign x_inf = (x_in.exp == FP_EXP_MAX) && (x_in.frac == '0);
    assign y_inf = (y_in.exp == FP_EXP_MAX) && (y_in.frac == '0);

    // NOTE: every combinational output gets a default first so no latch is inferred.
    always_comb begin
        s1_d         = '0;
        s1_d.eff_sub = eff_sub;
        s1_d.shamt   = (exp_diff >= 8'(SIG_W)) ? 5'(SIG_W) : exp_diff[4:0];
        if (swap) begin
            s1_d.mant_a = my;
            s1_d.mant_b = mx;
            s1_d.exp    = ey;
            s1_d.sign   = sy_eff;
        end else begin
            s1_d.mant_a = mx;
            s1_d.mant_b = my;
            s1_d.exp    = ex;
            s1_d.sign   = x_in.sign;
        end

        if (x_nan || y_nan || (x_inf && y_inf && eff_sub)) begin
            s1_d.special     = 1'b1;
            s1_d.special_val = FP_QNAN;
        end else if (x_inf) begin
            s1_d.special     = 1'b1;
            s1_d.special_val = {x_in.sign, FP_EXP_MAX, 23'd0};
        end else if (y_inf) begin
            s1_d.special     = 1'b1;
            s1_d.special_val = {sy_eff, FP_EXP_MAX, 23'd0};
        end
    end

    // ---------------- stage 2: shift, sticky, inversion ----------------
    assign b_word = {3'b000, s1_q.mant_b, 3'b000};

    fp_rshift_sticky u_rshift (
        .data_i   (b_word),
        .amt_i    (s1_q.shamt),
        .data_o   (b_shift),
        .sticky_o (b_sticky)
    );

    assign b_aligned = b_shift | {{(SIG_W-1){1'b0}}, b_sticky};

    always_comb begin
        s2_d             = '0;
        s2_d.a           = {5'b00000, s1_q.mant_a, 3'b000};
        s2_d.b           = s1_q.eff_sub ? ~{5'b00000, b_aligned} : {5'b00000, b_aligned};
        s2_d.cin         = s1_q.eff_sub;
        s2_d.exp         = s1_q.exp;
        s2_d.sign        = s1_q.sign;
        s2_d.eff_sub     = s1_q.eff_sub;
        s2_d.special     = s1_q.special;
        s2_d.special_val = s1_q.special_val;
    end

    // NOTE: state uses non-blocking assignments so both stages see pre-edge values.
    always_ff @(posedge clk) begin
        if (rst) begin
            s1_valid_q <= 1'b0;
            s1_q       <= '0;
            s2_valid_q <= 1'b0;
            s2_q       <= '0;
        end else begin
            if (bus.in_ready) begin
                s1_valid_q <= bus.in_valid;
                if (bus.in_valid) begin
                    s1_q <= s1_d;
                end
            end
            if (s2_advance) begin
                s2_valid_q <= s1_valid_q;
                if (s1_valid_q) begin
                    s2_q <= s2_d;
                end
            end
        end
    end

    assign bus.out_valid     = s2_valid_q;
    assign bus.a_o           = s2_q.a;
    assign bus.b_o           = s2_q.b;
    assign bus.cin_o         = s2_q.cin;
    assign bus.exp_o         = s2_q.exp;
    assign bus.sign_o        = s2_q.sign;
    assign bus.eff_sub_o     = s2_q.eff_sub;
    assign bus.special_o     = s2_q.special;
    assign bus.special_val_o = s2_q.special_val;

endmodule

// File: tb/tb_fp_align_stage.sv
// Directed self-checking bench for fp_align_stage (honours FP_ALIGN_STICKY_EN).
module tb_fp_align_stage;

`ifdef FP_ALIGN_STICKY_EN
    localparam logic STK = 1'b1;
`else
    localparam logic STK = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   n_checks = 0;
    int   n_errors = 0;

    always #5 clk = ~clk;

    fp_align_stage_if bus ();

    fp_align_stage dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // One pair through an otherwise empty pipeline; checks exact 2-cycle latency.
    task automatic run_vec(input string tag, input logic [31:0] x, input logic [31:0] y,
                           input logic op, input logic [31:0] ea, input logic [31:0] eb,
                           input logic ecin, input logic [7:0] eexp, input logic esign,
                           input logic espec, input logic [31:0] esval);
        @(negedge clk);
        bus.x_i       = x;
        bus.y_i       = y;
        bus.op_i      = op;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        #1;
        check({tag, ".in_ready"}, 64'(bus.in_ready), 64'd1);
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check({tag, ".early_valid"}, 64'(bus.out_valid), 64'd0);
        @(negedge clk);
        check({tag, ".out_valid"}, 64'(bus.out_valid), 64'd1);
        check({tag, ".special"}, 64'(bus.special_o), 64'(espec));
        check({tag, ".special_val"}, 64'(bus.special_val_o), 64'(esval));
        if (!espec) begin
            check({tag, ".a"}, 64'(bus.a_o), 64'(ea));
            check({tag, ".b"}, 64'(bus.b_o), 64'(eb));
            check({tag, ".cin"}, 64'(bus.cin_o), 64'(ecin));
            check({tag, ".eff_sub"}, 64'(bus.eff_sub_o), 64'(ecin));
            check({tag, ".exp"}, 64'(bus.exp_o), 64'(eexp));
            check({tag, ".sign"}, 64'(bus.sign_o), 64'(esign));
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] bp_x   [4];
        logic [63:0] bp_exp [4];
        logic [63:0] held;
        logic        held_v;
        int          tx;
        int          rx;

        bp_x[0] = 32'h3F800000; bp_exp[0] = {24'd0, 8'h7F, 32'h04000000};
        bp_x[1] = 32'h40000000; bp_exp[1] = {24'd0, 8'h80, 32'h04000000};
        bp_x[2] = 32'h40400000; bp_exp[2] = {24'd0, 8'h80, 32'h06000000};
        bp_x[3] = 32'h40800000; bp_exp[3] = {24'd0, 8'h81, 32'h04000000};

        bus.in_valid  = 1'b0;
        bus.out_ready = 1'b0;
        bus.x_i       = '0;
        bus.y_i       = '0;
        bus.op_i      = 1'b0;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        check("reset.out_valid", 64'(bus.out_valid), 64'd0);
        check("reset.in_ready", 64'(bus.in_ready), 64'd1);
        check("reset.a", 64'(bus.a_o), 64'd0);
        check("reset.b", 64'(bus.b_o), 64'd0);
        check("reset.special_val", 64'(bus.special_val_o), 64'd0);

        run_vec("add_1_1",      32'h3F800000, 32'h3F800000, 1'b0, 32'h04000000, 32'h04000000, 1'b0, 8'h7F, 1'b0, 1'b0, 32'h0);
        run_vec("sub_1_half",   32'h3F800000, 32'h3F000000, 1'b1, 32'h04000000, 32'hFDFFFFFF, 1'b1, 8'h7F, 1'b0, 1'b0, 32'h0);
        run_vec("add_half_1",   32'h3F000000, 32'h3F800000, 1'b0, 32'h04000000, 32'h02000000, 1'b0, 8'h7F, 1'b0, 1'b0, 32'h0);
        run_vec("add_tiny_d30", 32'h3F800000, 32'h30800000, 1'b0, 32'h04000000, {31'd0, STK},  1'b0, 8'h7F, 1'b0, 1'b0, 32'h0);
        run_vec("sticky_d4",    32'h3F800000, 32'h3D800001, 1'b0, 32'h04000000, {31'h00200000, STK}, 1'b0, 8'h7F, 1'b0, 1'b0, 32'h0);
        run_vec("grs_d25",      32'h3F800000, 32'h33000000, 1'b0, 32'h04000000, 32'h00000002, 1'b0, 8'h7F, 1'b0, 1'b0, 32'h0);
        run_vec("neg2_plus_1",  32'hC0000000, 32'h3F800000, 1'b0, 32'h04000000, 32'hFDFFFFFF, 1'b1, 8'h80, 1'b1, 1'b0, 32'h0);
        run_vec("1_minus_3",    32'h3F800000, 32'h40400000, 1'b1, 32'h06000000, 32'hFDFFFFFF, 1'b1, 8'h80, 1'b1, 1'b0, 32'h0);
        run_vec("eq_exp_swap",  32'h3F800000, 32'h3FC00000, 1'b1, 32'h06000000, 32'hFBFFFFFF, 1'b1, 8'h7F, 1'b1, 1'b0, 32'h0);
        run_vec("denorm_vs_min",32'h00800000, 32'h00400000, 1'b0, 32'h04000000, 32'h02000000, 1'b0, 8'h01, 1'b0, 1'b0, 32'h0);
        run_vec("inf_minus_inf",32'h7F800000, 32'h7F800000, 1'b1, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b1, 32'h7FC00000);
        run_vec("nan_x",        32'h7F800001, 32'h3F800000, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b1, 32'h7FC00000);
        run_vec("nan_y",        32'h3F800000, 32'hFFC00000, 1'b1, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b1, 32'h7FC00000);
        run_vec("inf_plus_1",   32'h7F800000, 32'h3F800000, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b1, 32'h7F800000);
        run_vec("1_minus_inf",  32'h3F800000, 32'h7F800000, 1'b1, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b1, 32'hFF800000);
        run_vec("ninf_add_ninf",32'hFF800000, 32'hFF800000, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b1, 32'hFF800000);
        run_vec("inf_add_ninf", 32'h7F800000, 32'hFF800000, 1'b0, 32'h0, 32'h0, 1'b0, 8'h0, 1'b0, 1'b1, 32'h7FC00000);

        // Backpressure: 4 pairs back-to-back, out_ready low in cycles 1..3.
        tx     = 0;
        rx     = 0;
        held   = '0;
        held_v = 1'b0;
        for (int c = 0; c < 16; c++) begin
            @(negedge clk);
            bus.out_ready = !(c >= 1 && c <= 3);
            bus.in_valid  = (tx < 4);
            bus.x_i       = bp_x[(tx < 4) ? tx : 0];
            bus.y_i       = 32'h0;
            bus.op_i      = 1'b0;
            #1;
            if (c == 2) check("bp.in_ready_full", 64'(bus.in_ready), 64'd0);
            if (held_v) check("bp.hold", {24'd0, bus.exp_o, bus.a_o}, held);
            held_v = bus.out_valid && !bus.out_ready;
            held   = {24'd0, bus.exp_o, bus.a_o};
            if (bus.out_valid && bus.out_ready) begin
                if (rx < 4) check($sformatf("bp.order%0d", rx), {24'd0, bus.exp_o, bus.a_o}, bp_exp[rx]);
                else        check("bp.duplicate", 64'd1, 64'd0);
                rx++;
            end
            if (bus.in_valid && bus.in_ready) tx++;
        end
        bus.in_valid = 1'b0;
        check("bp.accepted", 64'(tx), 64'd4);
        check("bp.delivered", 64'(rx), 64'd4);

        // Reset with both stages full discards everything.
        @(negedge clk);
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.x_i       = 32'h3F800000;
        bus.y_i       = 32'h3F800000;
        @(negedge clk);
        bus.x_i = 32'h40000000;
        @(negedge clk);
        bus.in_valid = 1'b0;
        #1;
        check("rst.pre_valid", 64'(bus.out_valid), 64'd1);
        rst = 1'b1;
        @(negedge clk);
        check("rst.out_valid", 64'(bus.out_valid), 64'd0);
        check("rst.in_ready", 64'(bus.in_ready), 64'd1);
        rst = 1'b0;
        @(negedge clk);
        check("rst.still_empty", 64'(bus.out_valid), 64'd0);
        run_vec("post_rst_add", 32'h3F800000, 32'h3F800000, 1'b0, 32'h04000000, 32'h04000000, 1'b0, 8'h7F, 1'b0, 1'b0, 32'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fp_align_stage.md
# fp_align_stage

Pre-adder alignment stage of the single-precision FP add/sub datapath. Accepts two IEEE-754 binary32 operands and an add/sub opcode, and orders them by magnitude. It right-shifts the smaller significand with guard/round/sticky bits and applies effective-subtraction inversion. It emits `a`, `b` and `cin` ready to drive `adder_sub` directly, plus the exponent, sign and special-case side information the normalise/round stage needs. Two-stage pipeline with valid/ready handshake on both sides.

## Interface
- No parameters; binary32 only.
- `clk` input 1: clock, all state on rising edge.
- `rst` input 1: synchronous, active-high reset.
- `in_valid` input 1: operand pair valid.
- `in_ready` output 1: stage accepts input this cycle.
- `x_i` input 32: operand X, binary32.
- `y_i` input 32: operand Y, binary32.
- `op_i` input 1: 0 = X+Y, 1 = X−Y.
- `out_valid` output 1: outputs valid.
- `out_ready` input 1: downstream accepts.
- `a_o` output 32: larger aligned significand, to `adder_sub.a`.
- `b_o` output 32: smaller aligned significand, inverted when `eff_sub_o`=1, to `adder_sub.b`.
- `cin_o` output 1: equals `eff_sub_o`, to `adder_sub.cin`.
- `exp_o` output 8: biased exponent of larger operand.
- `sign_o` output 1: result sign.
- `eff_sub_o` output 1: effective subtraction.
- `special_o` output 1: NaN/Inf result; downstream must use `special_val_o`.
- `special_val_o` output 32: final result when `special_o`=1, else 0.

## Operation
- Unpack: denormal/zero (exp=0) uses hidden=0 and effective exponent 1. Otherwise hidden=1.
- Significand word layout: bits [31:27]=0, [26]=hidden, [25:3]=fraction, [2:0]=G,R,S. The headroom absorbs the adder carry.
- Y effective sign: `sy ^ op_i`. `eff_sub = sx ^ sy ^ op_i`.
- Swap when (ey > ex) or (ey == ex and my > mx). The larger operand becomes A, so the adder result is never negative.
- `sign_o`: the effective sign of A. Exact-cancellation sign (+0) is the normaliser's job.
- Alignment: d = eA − eB ≥ 0. B word is shifted right by d. For d ≥ 27 the word is 0.
- Sticky (S, bit 0): OR of all bits shifted out below bit 0, ORed with the existing S.
- `b_o = eff_sub ? ~B_aligned : B_aligned`. `cin_o = eff_sub`.
- Specials are computed in stage 1:
  - Any NaN, or Inf with Inf under eff_sub: `special_val_o` = 0x7FC00000.
  - Exactly one Inf, or both Inf without eff_sub: that Inf with its effective sign.
- Significand outputs are don't-care when `special_o`=1.

## Timing
- Stage 1 registers unpack, compare, swap, d and specials. Stage 2 registers shift, sticky and inversion.
- Latency is 2 cycles from input handshake to `out_valid`. Throughput is 1 pair/cycle.
- Each stage register loads when empty or when the next stage advances in the same cycle.
- `in_ready = !s1_valid || s2_advance`. `s2_advance = !s2_valid || out_ready`.
- No combinational path from `in_valid` to `out_valid`.
- `in_ready` depends combinationally on `out_ready`.
- Outputs hold stable while `out_valid && !out_ready`.
- Reset: both valid flags and all output registers clear to 0, including `in_ready`-internal state. `in_ready`=1 in the first cycle after reset.
- Reset mid-stream: all in-flight pairs are discarded. `out_valid`=0 in the cycle after `rst` is sampled high.
- Simultaneous input accept and output drain with both stages full: the pipeline shifts, no bubble.

## Configuration
- `FP_ALIGN_STICKY_EN`
  - Defined: the S bit is computed as above.
  - Undefined: S is forced to 0 (truncating alignment), and the sticky OR-reduce logic is removed. G and R are still produced.

## Structure
- Package `fp_pkg` holds:
  - typedef `fp32_t` (sign, exp[7:0], frac[22:0]) and typedef `fp_align_t` (stage-2 payload);
  - constants `FP_EXP_MAX`=8'hFF, `FP_QNAN`=32'h7FC00000, `SIG_W`=27.
- One sub-module, `fp_rshift_sticky`: combinational 27-bit right shifter with 5-bit amount, saturating at ≥27, and sticky output. It is instantiated in stage 2.

## Test plan
- 1.0 + 1.0 (0x3F800000, 0x3F800000, op=0) -> 2 cycles later: `a_o`=0x04000000, `b_o`=0x04000000, `cin_o`=0, `exp_o`=0x7F, `sign_o`=0.
- 1.0 − 0.5 (0x3F800000, 0x3F000000, op=1) -> `a_o`=0x04000000, `b_o`=0xFDFFFFFF, `cin_o`=1, `exp_o`=0x7F. Chained `adder_sub` gives sum 0x02000000 with cout=1.
- 0.5 + 1.0 (operands swapped) -> `a_o`=0x04000000, `b_o`=0x02000000, `sign_o`=0.
- 1.0 + 2^-30 (y=0x30800000) -> `b_o`=0x00000001 with `FP_ALIGN_STICKY_EN`, 0x00000000 without.
- Inf − Inf (0x7F800000, 0x7F800000, op=1) -> `special_o`=1, `special_val_o`=0x7FC00000. NaN in either operand gives the same.
- Backpressure:
  - Stimulus: stream 4 pairs back-to-back with `out_ready`=0 for 3 cycles.
  - Required: `in_ready` falls once both stages are full, outputs hold stable, and all 4 results emerge in order with none dropped or duplicated.
  - Follow-up: assert `rst` mid-stream -> `out_valid`=0 the next cycle.
